sense_sampler: RTL and testbench

- Clocked, parametrised successor to the single-bit sense fetch/push chain.
- On activation it does three things per iteration:
  - samples a WIDTH-bit vector of asynchronous sense inputs through a synchroniser;
  - passes the sample through two holding stages (fetch stage, then copy stage);
  - pushes the result downstream on a four-phase req/ack bundled-data channel.
- Supports single-shot or continuous-loop operation, and optional change-only suppression.
- Sits between raw sense pins and a consumer of push-channel data.

---
 rtl/sense_sampler_if.sv | 32 +++
 rtl/sense_sampler.sv | 175 +++++++++++++++++
 tb/tb_sense_sampler.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sense_sampler_if.sv
// Handshake bundle for sense_sampler.
// Carries the activation channel, the loop-mode select and the four-phase
// bundled-data push channel. The sampler uses the master side; the
// environment (activator and push consumer) uses the slave side.
interface sense_sampler_if #(
   parameter int WIDTH = 4
);
   logic             activate_0r;
   logic             activate_0a;
   logic             mode_loop;
   logic             push_0r;
   logic             push_0a;
   logic [WIDTH-1:0] push_0d;

   modport master (
      input  activate_0r,
      input  mode_loop,
      input  push_0a,
      output activate_0a,
      output push_0r,
      output push_0d
   );

   modport slave (
      output activate_0r,
      output mode_loop,
      output push_0a,
      input  activate_0a,
      input  push_0r,
      input  push_0d
   );
endinterface

// File: rtl/sense_sampler.sv
// sense_sampler: clocked sense fetch/copy/push chain.
// A WIDTH-bit vector of asynchronous sense pins is synchronised, fetched
// into stage_a, copied into stage_b and pushed downstream on a four-phase
// req/ack bundled-data channel. Single-shot mode acknowledges the activation
// after one push; loop mode repeats while activate_0r stays high and never
// acknowledges. CHANGE_ONLY suppresses repeated values in loop mode.
// Optional build macro SENSE_DEBOUNCE_EN adds a per-channel debounce counter
// between the synchroniser and sense_sync.
module sense_sampler #(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int CHANGE_ONLY     = 0,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             initialise_n,
   sense_sampler_if.master  bus,
   input  logic [WIDTH-1:0] sense,
   output logic [WIDTH-1:0] sense_sync
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      COPY     = 3'd2,
      PUSH_REQ = 3'd3,
      PUSH_RTZ = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] stage_a_q, stage_a_d;
   logic [WIDTH-1:0] stage_b_q, stage_b_d;
   logic [WIDTH-1:0] push_0d_q, push_0d_d;
   logic             push_0r_q, push_0r_d;
   logic             act_a_q, act_a_d;
   logic             has_pushed_q, has_pushed_d;
   logic             loop_q, loop_d;
   logic             suppress;

   // Synchroniser: stage 0 takes the raw pins, last stage is the clean copy.
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

   // Shift the sense vector through the synchroniser chain.
   always_ff @(posedge clk) begin
      if (!initialise_n) sync_q <= '0;
      else               sync_q <= {sync_q[SYNC_STAGES-2:0], sense};
   end

`ifdef SENSE_DEBOUNCE_EN
   // Each channel only follows the synchroniser once it has disagreed with
   // the published value for DEBOUNCE_CYCLES consecutive samples.
   for (genvar c = 0; c < WIDTH; c++) begin : g_db
      logic [7:0] cnt_q, cnt_d;
      logic       bit_q, bit_d;

      // Count consecutive disagreeing samples; any agreement restarts.
      always_comb begin
         cnt_d = '0;
         bit_d = bit_q;
         if (sync_q[SYNC_STAGES-1][c] != bit_q) begin
            if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) bit_d = sync_q[SYNC_STAGES-1][c];
            else                                  cnt_d = cnt_q + 8'd1;
         end
      end

      // Debounce counter and published bit.
      always_ff @(posedge clk) begin
         if (!initialise_n) begin
            cnt_q <= '0;
            bit_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            bit_q <= bit_d;
         end
      end

      assign sense_sync[c] = bit_q;
   end
`else
   assign sense_sync = sync_q[SYNC_STAGES-1];
`endif

   // In loop mode with change suppression, skip a push that would repeat the
   // last pushed value; never before the first push after reset.
   assign suppress = (CHANGE_ONLY != 0) && loop_q && has_pushed_q &&
                     (stage_a_q == push_0d_q);

   // Next-state and registered-output logic for the fetch/copy/push sequence.
   always_comb begin
      state_d      = state_q;
      stage_a_d    = stage_a_q;
      stage_b_d    = stage_b_q;
      push_0d_d    = push_0d_q;
      push_0r_d    = push_0r_q;
      act_a_d      = act_a_q;
      has_pushed_d = has_pushed_q;
      loop_d       = loop_q;
      case (state_q)
         IDLE: begin
            if (bus.activate_0r) begin
               loop_d  = bus.mode_loop;
               state_d = FETCH;
            end
         end
         FETCH: begin
            stage_a_d = sense_sync;
            state_d   = COPY;
         end
         COPY: begin
            stage_b_d = stage_a_q;
            if (suppress) begin
               state_d = FETCH;
            end else begin
               push_0d_d = stage_a_q;
               push_0r_d = 1'b1;
               state_d   = PUSH_REQ;
            end
         end
         PUSH_REQ: begin
            if (bus.push_0a) begin
               push_0r_d    = 1'b0;
               has_pushed_d = 1'b1;
               state_d      = PUSH_RTZ;
            end
         end
         PUSH_RTZ: begin
            // Abort/continue is only decided here, after the push completes.
            if (!bus.push_0a) begin
               if (loop_q) begin
                  state_d = bus.activate_0r ? FETCH : IDLE;
               end else begin
                  act_a_d = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (!bus.activate_0r) begin
               act_a_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!initialise_n) begin
         state_q      <= IDLE;
         stage_a_q    <= '0;
         stage_b_q    <= '0;
         push_0d_q    <= '0;
         push_0r_q    <= 1'b0;
         act_a_q      <= 1'b0;
         has_pushed_q <= 1'b0;
         loop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         stage_a_q    <= stage_a_d;
         stage_b_q    <= stage_b_d;
         push_0d_q    <= push_0d_d;
         push_0r_q    <= push_0r_d;
         act_a_q      <= act_a_d;
         has_pushed_q <= has_pushed_d;
         loop_q       <= loop_d;
      end
   end

   assign bus.push_0r     = push_0r_q;
   assign bus.push_0d     = push_0d_q;
   assign bus.activate_0a = act_a_q;

endmodule

// File: tb/tb_sense_sampler.sv
// Directed bench for sense_sampler. Two instances share clock, reset and
// sense pins: u_dut0 with CHANGE_ONLY=0, u_dut1 with CHANGE_ONLY=1.
// A negedge process per channel plays the push consumer (ack after dly
// negedges) and logs every push rise with its edge number.
module tb_sense_sampler;
   localparam int W  = 4;
   localparam int SS = 2;
`ifdef SENSE_DEBOUNCE_EN
   localparam int DB  = 4;
   localparam int LAT = SS + DB;
`else
   localparam int LAT = SS;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] sense = '0;
   logic [W-1:0] ss0, ss1;
   int           cyc = 0;
   int           n_chk = 0;
   int           n_fail = 0;

   sense_sampler_if #(.WIDTH(W)) b0 ();
   sense_sampler_if #(.WIDTH(W)) b1 ();

   sense_sampler #(.WIDTH(W), .SYNC_STAGES(SS), .CHANGE_ONLY(0), .DEBOUNCE_CYCLES(4)) u_dut0 (
      .clk(clk), .initialise_n(rst_n), .bus(b0), .sense(sense), .sense_sync(ss0));
   sense_sampler #(.WIDTH(W), .SYNC_STAGES(SS), .CHANGE_ONLY(1), .DEBOUNCE_CYCLES(4)) u_dut1 (
      .clk(clk), .initialise_n(rst_n), .bus(b1), .sense(sense), .sense_sync(ss1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // consumer model + push log
   int           dly0 = 0, dly1 = 0, cnt0 = 0, cnt1 = 0;
   logic         pr0 = 1'b0, pr1 = 1'b0, hs0 = 1'b0;
   logic [W-1:0] hold0 = '0;
   int           unstable0 = 0, aa0 = 0;
   logic [W-1:0] q0[$], q1[$];
   int           t0[$], t1[$];

   always @(negedge clk) begin
      if (b0.push_0r && !pr0) begin
         q0.push_back(b0.push_0d); t0.push_back(cyc); hold0 = b0.push_0d; hs0 = 1'b1;
      end else if (hs0 && rst_n && b0.push_0d !== hold0) unstable0++;
      if (!rst_n || (!b0.push_0r && !b0.push_0a)) hs0 = 1'b0;
      if (b0.activate_0a) aa0++;
      pr0 = b0.push_0r;
      if (!b0.push_0r) begin b0.push_0a = 1'b0; cnt0 = 0; end
      else if (cnt0 >= dly0) b0.push_0a = 1'b1;
      else cnt0++;

      if (b1.push_0r && !pr1) begin q1.push_back(b1.push_0d); t1.push_back(cyc); end
      pr1 = b1.push_0r;
      if (!b1.push_0r) begin b1.push_0a = 1'b0; cnt1 = 0; end
      else if (cnt1 >= dly1) b1.push_0a = 1'b1;
      else cnt1++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      b0.activate_0r = 1'b0; b0.mode_loop = 1'b0;
      b1.activate_0r = 1'b0; b1.mode_loop = 1'b0;
      rst_n = 1'b0; sense = '0;
      tick(3);
      @(negedge clk);
      n_chk++; if (b0.push_0r !== 1'b0) begin n_fail++; $display("FAIL reset_push_0r0: got %b want 0", b0.push_0r); end
      n_chk++; if (b0.push_0d !== 4'h0) begin n_fail++; $display("FAIL reset_push_0d0: got %h want 0", b0.push_0d); end
      n_chk++; if (b0.activate_0a !== 1'b0) begin n_fail++; $display("FAIL reset_act_a0: got %b want 0", b0.activate_0a); end
      n_chk++; if (ss0 !== 4'h0) begin n_fail++; $display("FAIL reset_sense_sync0: got %h want 0", ss0); end
      n_chk++; if (b1.push_0r !== 1'b0 || b1.activate_0a !== 1'b0) begin n_fail++; $display("FAIL reset_dut1_outs: got r=%b a=%b want 0 0", b1.push_0r, b1.activate_0a); end
      rst_n = 1'b1;
      tick(1);
   endtask

`ifdef SENSE_DEBOUNCE_EN
   task automatic test_debounce();
      logic stayed;
      int   c;
      tick(LAT + 2);
      sense[0] = 1'b1; tick(2); sense[0] = 1'b0;
      stayed = 1'b1;
      for (int i = 0; i < 12; i++) begin @(negedge clk); if (ss0[0] !== 1'b0) stayed = 1'b0; end
      n_chk++; if (stayed !== 1'b1) begin n_fail++; $display("FAIL debounce_glitch: sense_sync[0] rose, want held 0"); end
      tick(1);
      c = cyc; sense[0] = 1'b1;
      tick(SS + DB - 1); @(negedge clk);
      n_chk++; if (ss0[0] !== 1'b0) begin n_fail++; $display("FAIL debounce_early: got %b want 0 at edge %0d", ss0[0], cyc - c); end
      tick(1); @(negedge clk);
      n_chk++; if (ss0[0] !== 1'b1) begin n_fail++; $display("FAIL debounce_update: got %b want 1 at edge %0d", ss0[0], cyc - c); end
      sense[0] = 1'b0;
      tick(LAT + 2);
   endtask
`else
   task automatic test_sync_latency();
      sense = 4'h9;
      tick(SS - 1); @(negedge clk);
      n_chk++; if (ss0 !== 4'h0) begin n_fail++; $display("FAIL sync_early: got %h want 0", ss0); end
      tick(1); @(negedge clk);
      n_chk++; if (ss0 !== 4'h9) begin n_fail++; $display("FAIL sync_latency: got %h want 9", ss0); end
      tick(2);
   endtask
`endif

   task automatic test_single_shot();
      int base, k, w, tdone;
      sense = 4'hA; b0.mode_loop = 1'b0; dly0 = 0;
      tick(LAT + 2);
      base = q0.size(); k = cyc + 1;
      b0.activate_0r = 1'b1;
      tick(1);
      b0.mode_loop = 1'b1;  // outside IDLE: must be ignored
      w = 0;
      while (w < 40 && b0.activate_0a !== 1'b1) begin @(negedge clk); w++; end
      tdone = cyc;
      n_chk++; if (w >= 40) begin n_fail++; $display("FAIL single_timeout: activate_0a never rose"); end
      n_chk++; if (tdone != k + 4) begin n_fail++; $display("FAIL single_ack_time: got edge k+%0d want k+4", tdone - k); end
      tick(1);
      b0.activate_0r = 1'b0; b0.mode_loop = 1'b0;
      tick(1); @(negedge clk);
      n_chk++; if (b0.activate_0a !== 1'b0) begin n_fail++; $display("FAIL single_ack_fall: got %b want 0", b0.activate_0a); end
      tick(6);
      n_chk++; if (q0.size() - base != 1) begin n_fail++; $display("FAIL single_count: got %0d pushes want 1", q0.size() - base); end
      else begin
         n_chk++; if (q0[base] !== 4'hA) begin n_fail++; $display("FAIL single_data: got %h want a", q0[base]); end
         n_chk++; if (t0[base] != k + 2) begin n_fail++; $display("FAIL single_req_time: got edge k+%0d want k+2", t0[base] - k); end
      end
   endtask

   task automatic test_loop();
      int base, a0, k;
      logic [W-1:0] exp_v [3];
      exp_v[0] = 4'h1; exp_v[1] = 4'h2; exp_v[2] = 4'h3;
      base = q0.size(); a0 = aa0;
      sense = 4'h1; b0.mode_loop = 1'b1; dly0 = 0;
      k = cyc + LAT + 4;
      while (cyc < k + 20) begin
         if (cyc == k - 1)       b0.activate_0r = 1'b1;
         if (cyc == k + 3 - LAT) sense = 4'h2;
         if (cyc == k + 7 - LAT) sense = 4'h3;
         if (cyc == k + 10)      b0.activate_0r = 1'b0;  // drop during PUSH_REQ
         tick(1);
      end
      n_chk++; if (q0.size() - base != 3) begin n_fail++; $display("FAIL loop_count: got %0d pushes want 3", q0.size() - base); end
      else begin
         for (int i = 0; i < 3; i++) begin
            n_chk++; if (q0[base+i] !== exp_v[i]) begin n_fail++; $display("FAIL loop_data%0d: got %h want %h", i, q0[base+i], exp_v[i]); end
            n_chk++; if (t0[base+i] != k + 2 + 4*i) begin n_fail++; $display("FAIL loop_time%0d: got edge k+%0d want k+%0d", i, t0[base+i] - k, 2 + 4*i); end
         end
      end
      n_chk++; if (aa0 != a0) begin n_fail++; $display("FAIL loop_act_a: activate_0a high %0d cycles want 0", aa0 - a0); end
      n_chk++; if (b0.push_0r !== 1'b0) begin n_fail++; $display("FAIL loop_idle: push_0r=%b want 0", b0.push_0r); end
      b0.mode_loop = 1'b0;
   endtask

   task automatic test_change_only();
      int base;
      logic [W-1:0] exp_v [4];
      exp_v[0] = 4'h0; exp_v[1] = 4'h5; exp_v[2] = 4'h6; exp_v[3] = 4'h7;
      sense = 4'h0; b1.mode_loop = 1'b1; dly1 = 0;
      tick(LAT + 2);
      base = q1.size();
      b1.activate_0r = 1'b1;
      tick(10);
      sense = 4'h5; tick(20);
      sense = 4'h6; tick(15);
      sense = 4'h7; b1.activate_0r = 1'b0;
      tick(LAT + 15);
      sense = 4'h8;   // unit should be idle now
      tick(LAT + 8);
      n_chk++; if (q1.size() - base != 4) begin n_fail++; $display("FAIL chg_count: got %0d pushes want 4", q1.size() - base); end
      else begin
         for (int i = 0; i < 4; i++) begin
            n_chk++; if (q1[base+i] !== exp_v[i]) begin n_fail++; $display("FAIL chg_data%0d: got %h want %h", i, q1[base+i], exp_v[i]); end
         end
      end
      b1.mode_loop = 1'b0;
   endtask

   task automatic test_slow_consumer();
      int base, u0, k, w, tdone;
      sense = 4'h3; b0.mode_loop = 1'b0; dly0 = 10;
      tick(LAT + 2);
      base = q0.size(); u0 = unstable0; k = cyc + 1;
      b0.activate_0r = 1'b1;
      w = 0;
      while (w < 20 && b0.push_0r !== 1'b1) begin @(negedge clk); w++; end
      tick(1);
      sense = 4'hC;
      while (w < 80 && b0.activate_0a !== 1'b1) begin @(negedge clk); w++; end
      tdone = cyc;
      n_chk++; if (w >= 80) begin n_fail++; $display("FAIL slow_timeout: handshake did not finish"); end
      n_chk++; if (tdone != k + 14) begin n_fail++; $display("FAIL slow_ack_time: got edge k+%0d want k+14", tdone - k); end
      n_chk++; if (b0.push_0d !== 4'h3) begin n_fail++; $display("FAIL slow_hold: got %h want 3", b0.push_0d); end
      tick(1);
      b0.activate_0r = 1'b0; dly0 = 0;
      tick(3);
      n_chk++; if (q0.size() - base != 1 || q0[base] !== 4'h3) begin n_fail++; $display("FAIL slow_data: got %0d pushes first %h want 1 of 3", q0.size() - base, q0[base]); end
      n_chk++; if (unstable0 != u0) begin n_fail++; $display("FAIL slow_stable: push_0d moved %0d times want 0", unstable0 - u0); end
   endtask

   task automatic test_reset_mid_push();
      int base, k, w, tdone;
      sense = 4'h3; b0.mode_loop = 1'b0; dly0 = 10;
      tick(LAT + 2);
      b0.activate_0r = 1'b1;
      w = 0;
      while (w < 20 && b0.push_0r !== 1'b1) begin @(negedge clk); w++; end
      n_chk++; if (w >= 20) begin n_fail++; $display("FAIL rst_timeout: push_0r never rose"); end
      tick(2);
      rst_n = 1'b0; b0.activate_0r = 1'b0;
      tick(1); @(negedge clk);
      n_chk++; if (b0.push_0r !== 1'b0) begin n_fail++; $display("FAIL rst_push_0r: got %b want 0", b0.push_0r); end
      n_chk++; if (b0.push_0d !== 4'h0) begin n_fail++; $display("FAIL rst_push_0d: got %h want 0", b0.push_0d); end
      n_chk++; if (ss0 !== 4'h0) begin n_fail++; $display("FAIL rst_sense_sync: got %h want 0", ss0); end
      rst_n = 1'b1; dly0 = 0; sense = 4'h6;
      tick(LAT + 2);
      base = q0.size(); k = cyc + 1;
      b0.activate_0r = 1'b1;
      w = 0;
      while (w < 40 && b0.activate_0a !== 1'b1) begin @(negedge clk); w++; end
      tdone = cyc;
      n_chk++; if (tdone != k + 4) begin n_fail++; $display("FAIL rst_reactivate: ack at edge k+%0d want k+4", tdone - k); end
      tick(1);
      b0.activate_0r = 1'b0;
      tick(3);
      n_chk++; if (q0.size() - base != 1 || q0[base] !== 4'h6 || t0[base] != k + 2) begin
         n_fail++; $display("FAIL rst_repush: got %0d pushes data %h at k+%0d want 1 of 6 at k+2", q0.size() - base, q0[base], t0[base] - k);
      end
   endtask

   initial begin
      test_reset();
`ifdef SENSE_DEBOUNCE_EN
      test_debounce();
`else
      test_sync_latency();
`endif
      test_single_shot();
      test_loop();
      test_change_only();
      test_slow_consumer();
      test_reset_mid_push();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
